temp_mem_arbiter: RTL and testbench
===================================

Name: temp_mem_arbiter

Overview:
- Arbitrates the CiM temporary-result storage port among the 7 memory access sources: BUS_FSM, LOGIC_FSM, DATA_FILL_FSM, DENSE_BROADCAST_SAVE_FSM, MAC, LAYERNORM and SOFTMAX.
- The storage is single-ported, so one access (read or write) is issued per cycle.
- Round-robin selection across sources; read data is tagged and returned to the issuing source after a fixed memory latency.
- Sits between the CiM sub-FSMs/compute units and the temp storage SRAM wrapper.

Parameters:
NUM_SRC, 7, number of requesters (matches MEM_ACCESS_SRC_NUM); bit i corresponds to source enum value i
ADDR_W, 10, storage address width (clog2 of TEMP_RES_STORAGE_SIZE_CIM)
DATA_W, 22, storage word width (N_STORAGE)
RD_LAT, 2, cycles from mem_en (read) to mem_rdata valid; legal range 1..4
CNT_W, 16, width of the conflict counter

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_rd  in  NUM_SRC  per-source read request, held until granted
req_wr  in  NUM_SRC  per-source write request, held until granted
req_addr  in  NUM_SRC*ADDR_W  per-source address; slice i = [i*ADDR_W +: ADDR_W]
req_wdata  in  NUM_SRC*DATA_W  per-source write data, same slicing
grant  out  NUM_SRC  one-hot (or zero); the source's access is issued this cycle
rd_valid  out  NUM_SRC  one-hot; rd_data belongs to the flagged source
rd_data  out  DATA_W  returned read data
mem_en  out  1  storage access strobe
mem_wen  out  1  1 = write, 0 = read (valid with mem_en)
mem_addr  out  ADDR_W  storage address
mem_wdata  out  DATA_W  storage write data
mem_rdata  in  DATA_W  storage read data, valid RD_LAT cycles after a read strobe
conflict_cnt  out  CNT_W  count of cycles with 2 or more active requesters (saturating)
err_rw_same_src  out  1  sticky; some source asserted req_rd and req_wr in the same cycle

Behaviour:
- Active requester i: req_rd[i] | req_wr[i].
- Arbitration:
  - Combinational, same cycle.
  - Winner is the first active requester at or after rr_ptr, scanning upward and wrapping at NUM_SRC-1 to 0.
  - grant[winner] = 1; at most one grant bit per cycle; grant = 0 if no requester is active.
- mem_en, mem_wen, mem_addr and mem_wdata are driven combinationally from the winner in the grant cycle:
  - mem_en = |grant.
  - mem_wen = req_wr[winner].
  - mem_addr and mem_wdata are 0 when nothing is granted.
- rr_ptr register:
  - Reset value 0.
  - On any grant: rr_ptr <= winner + 1, wrapping NUM_SRC-1 to 0.
  - Unchanged when idle.
- Requesters hold req/addr/wdata stable until they see grant high. They may drop the request the cycle after the grant, or keep it high to request again.
- Same source with req_rd and req_wr both high in one cycle:
  - Treated as a write only; no read is issued.
  - err_rw_same_src <= 1 and stays set until rst.
- Read return:
  - A tag pipeline of RD_LAT stages, each NUM_SRC bits wide.
  - Stage 0 loads grant & ~mem_wen.
  - rd_valid = last stage.
  - rd_data = mem_rdata passthrough, gated to 0 when rd_valid == 0.
- Read latency is exactly RD_LAT cycles from grant to rd_valid. A back-to-back grant every cycle yields one rd_valid every cycle.
- Writes produce no rd_valid.
- A write and an older read's return may coincide in the same cycle; no hazard. Address ordering is the requesters' responsibility.
- conflict_cnt:
  - Increments by 1 on each cycle with popcount(active) >= 2.
  - Saturates at all-ones; never wraps.
- Reset (sync, rst = 1 at a rising edge):
  - rr_ptr = 0, tag pipeline cleared, conflict_cnt = 0, err_rw_same_src = 0.
  - While rst is high, grant = 0 and mem_en = 0, regardless of requests.
  - In-flight reads at reset are dropped: no rd_valid ever appears for them.
- Single-requester steady state: the source is granted every cycle; rr_ptr has no effect.

Test Plan:
1. Single read, RD_LAT = 2: MAC (bit 4) sets req_rd with addr 0x03A at cycle t. Required: grant = 7'b0010000, mem_en = 1, mem_wen = 0, mem_addr = 0x03A at t; rd_valid = 7'b0010000 with rd_data = mem_rdata at t+2.
2. Round-robin fairness: sources 0, 3 and 6 hold req_wr continuously after reset. Required grant order 0, 3, 6, 0, 3, 6. conflict_cnt = 6 after 6 cycles.
3. Mixed back-to-back: LAYERNORM reads and SOFTMAX writes 0x2A5A5A to 0x100, both active at t with rr_ptr = 0. Required:
   - t: LAYERNORM read.
   - t+1: SOFTMAX write, mem_wdata = 0x2A5A5A.
   - t+2: rd_valid for LAYERNORM only.
   - No rd_valid for the write.
4. RW collision: BUS_FSM asserts req_rd and req_wr together. Required: write issued (mem_wen = 1), no rd_valid, err_rw_same_src = 1 and held after the request is released.
5. Reset mid-operation: issue reads at t and t+1, assert rst at t+1 for 1 cycle. Required: no rd_valid at t+2 or t+3; conflict_cnt = 0; the next grant starts scanning at source 0.
6. Saturation: with CNT_W = 4, hold 2 requesters for 20 cycles. Required: conflict_cnt stops at 15.

Source files
------------

// File: rtl/temp_mem_arbiter.sv
// Round-robin arbiter for the single-ported CiM temp-result storage.
// Issues one access per cycle and returns tagged read data after RD_LAT cycles.
module temp_mem_arbiter #(
    parameter int unsigned NUM_SRC = 7,
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned DATA_W  = 22,
    parameter int unsigned RD_LAT  = 2,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_SRC-1:0]          req_rd,
    input  logic [NUM_SRC-1:0]          req_wr,
    input  logic [NUM_SRC*ADDR_W-1:0]   req_addr,
    input  logic [NUM_SRC*DATA_W-1:0]   req_wdata,
    output logic [NUM_SRC-1:0]          grant,
    output logic [NUM_SRC-1:0]          rd_valid,
    output logic [DATA_W-1:0]           rd_data,
    output logic                        mem_en,
    output logic                        mem_wen,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic [DATA_W-1:0]           mem_rdata,
    output logic [CNT_W-1:0]            conflict_cnt,
    output logic                        err_rw_same_src
);

    localparam int unsigned PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int unsigned IDX_W = PTR_W + 1;
    localparam int unsigned TAG_W = RD_LAT * NUM_SRC;

    logic [NUM_SRC-1:0] active;
    logic               multi;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]   winner;
    logic [IDX_W-1:0]   idx;
    logic               found;
    logic [NUM_SRC-1:0] rd_issue;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;

    assign active = req_rd | req_wr;
    assign multi  = |(active & (active - NUM_SRC'(1)));

    // Find the first active requester at or after rr_ptr, wrapping at NUM_SRC-1.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int unsigned off = 0; off < NUM_SRC; off++) begin
            idx = IDX_W'(rr_ptr_q) + IDX_W'(off);
            if (idx >= IDX_W'(NUM_SRC)) begin
                idx = idx - IDX_W'(NUM_SRC);
            end
            if (!found && active[idx[PTR_W-1:0]]) begin
                found  = 1'b1;
                winner = idx[PTR_W-1:0];
            end
        end
    end

    // Grant and storage-port drive; a simultaneous rd+wr from one source is a write.
    always_comb begin
        grant     = '0;
        mem_en    = 1'b0;
        mem_wen   = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (found && !rst) begin
            grant[winner] = 1'b1;
            mem_en        = 1'b1;
            mem_wen       = req_wr[winner];
            mem_addr      = req_addr[32'(winner)*ADDR_W +: ADDR_W];
            mem_wdata     = req_wdata[32'(winner)*DATA_W +: DATA_W];
        end
    end

    assign rd_issue = grant & ~{NUM_SRC{mem_wen}};

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (mem_en) begin
            rr_ptr_d = (winner == PTR_W'(NUM_SRC - 1)) ? '0 : winner + PTR_W'(1);
        end
    end

    // Tag pipeline: newest read tag enters at the low slice, oldest falls off the top.
    assign tag_d = TAG_W'({tag_q, rd_issue});

    assign cnt_d = (multi && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;
    assign err_d = err_q | (|(req_rd & req_wr));

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
            tag_q    <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            tag_q    <= tag_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    assign rd_valid        = tag_q[TAG_W-1 -: NUM_SRC];
    assign rd_data         = (|rd_valid) ? mem_rdata : '0;
    assign conflict_cnt    = cnt_q;
    assign err_rw_same_src = err_q;

endmodule

// File: tb/tb_temp_mem_arbiter.sv
// Bench for temp_mem_arbiter: directed scenarios plus random traffic against a
// cycle-level reference model (scan order, latency queue, saturating counter).
module tb_temp_mem_arbiter;

    localparam int unsigned NUM_SRC = 7;
    localparam int unsigned ADDR_W  = 10;
    localparam int unsigned DATA_W  = 22;
    localparam int unsigned RD_LAT  = 2;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned CNT_WS  = 4;
    localparam int unsigned MAXCYC  = 4096;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NUM_SRC-1:0]        req_rd, req_wr;
    logic [NUM_SRC*ADDR_W-1:0] req_addr;
    logic [NUM_SRC*DATA_W-1:0] req_wdata;
    logic [DATA_W-1:0]         mem_rdata;

    logic [NUM_SRC-1:0] grant, rd_valid;
    logic [DATA_W-1:0]  rd_data, mem_wdata;
    logic               mem_en, mem_wen, err_rw_same_src;
    logic [ADDR_W-1:0]  mem_addr;
    logic [CNT_W-1:0]   conflict_cnt;

    logic [NUM_SRC-1:0] s_grant, s_rd_valid;
    logic [DATA_W-1:0]  s_rd_data, s_mem_wdata;
    logic               s_mem_en, s_mem_wen, s_err;
    logic [ADDR_W-1:0]  s_mem_addr;
    logic [CNT_WS-1:0]  s_conflict_cnt;

    temp_mem_arbiter #(
        .NUM_SRC(NUM_SRC), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .req_rd(req_rd), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .grant(grant), .rd_valid(rd_valid), .rd_data(rd_data),
        .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .conflict_cnt(conflict_cnt), .err_rw_same_src(err_rw_same_src)
    );

    temp_mem_arbiter #(
        .NUM_SRC(NUM_SRC), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .CNT_W(CNT_WS)
    ) dut_sat (
        .clk(clk), .rst(rst), .req_rd(req_rd), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .grant(s_grant), .rd_valid(s_rd_valid), .rd_data(s_rd_data),
        .mem_en(s_mem_en), .mem_wen(s_mem_wen), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
        .mem_rdata(mem_rdata), .conflict_cnt(s_conflict_cnt), .err_rw_same_src(s_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int unsigned        cyc;
    int unsigned        m_rr;
    int unsigned        m_cnt, m_cnt_s;
    bit                 m_err;
    logic [NUM_SRC-1:0] exp_valid [MAXCYC];

    logic [NUM_SRC-1:0] obs_grant, obs_valid;
    logic               obs_wen, obs_err;
    logic [DATA_W-1:0]  obs_wdata;
    logic [CNT_W-1:0]   obs_cnt;
    logic [CNT_WS-1:0]  obs_cnt_s;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [NUM_SRC-1:0] onehot(input int unsigned i);
        return NUM_SRC'(1) << i;
    endfunction

    // One clock cycle: check every output against the model, then advance the model.
    task automatic step(input bit do_rst);
        logic [NUM_SRC-1:0] act, eg;
        logic [ADDR_W-1:0]  ea;
        logic [DATA_W-1:0]  ed;
        int unsigned        win, i;
        bit                 found, ewen;
        rst       = do_rst;
        mem_rdata = DATA_W'($urandom);
        #2;
        act   = req_rd | req_wr;
        found = 1'b0;
        win   = 0;
        if (!do_rst) begin
            for (int unsigned off = 0; off < NUM_SRC; off++) begin
                i = (m_rr + off) % NUM_SRC;
                if (!found && act[i]) begin
                    found = 1'b1;
                    win   = i;
                end
            end
        end
        eg = '0; ewen = 1'b0; ea = '0; ed = '0;
        if (found) begin
            eg   = onehot(win);
            ewen = req_wr[win];
            ea   = req_addr[win*ADDR_W +: ADDR_W];
            ed   = req_wdata[win*DATA_W +: DATA_W];
        end
        check_eq("grant", 64'(grant), 64'(eg));
        check_eq("mem_en", 64'(mem_en), 64'(found));
        if (found) check_eq("mem_wen", 64'(mem_wen), 64'(ewen));
        check_eq("mem_addr", 64'(mem_addr), 64'(ea));
        check_eq("mem_wdata", 64'(mem_wdata), 64'(ed));
        check_eq("rd_valid", 64'(rd_valid), 64'(exp_valid[cyc]));
        check_eq("rd_data", 64'(rd_data), (exp_valid[cyc] != '0) ? 64'(mem_rdata) : 64'(0));
        check_eq("conflict_cnt", 64'(conflict_cnt), 64'(m_cnt));
        check_eq("conflict_cnt_sat", 64'(s_conflict_cnt), 64'(m_cnt_s));
        check_eq("err_rw_same_src", 64'(err_rw_same_src), 64'(m_err));
        obs_grant = grant;  obs_valid = rd_valid; obs_wen = mem_wen;
        obs_wdata = mem_wdata; obs_err = err_rw_same_src;
        obs_cnt   = conflict_cnt; obs_cnt_s = s_conflict_cnt;
        if (do_rst) begin
            m_rr = 0; m_cnt = 0; m_cnt_s = 0; m_err = 1'b0;
            for (int unsigned k = cyc + 1; k < MAXCYC; k++) exp_valid[k] = '0;
        end else begin
            if (found) begin
                m_rr = (win + 1) % NUM_SRC;
                if (!ewen) exp_valid[cyc + RD_LAT] = eg;
            end
            if ($countones(act) >= 2) begin
                if (m_cnt < (1 << CNT_W) - 1)    m_cnt++;
                if (m_cnt_s < (1 << CNT_WS) - 1) m_cnt_s++;
            end
            if ((req_rd & req_wr) != '0) m_err = 1'b1;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        req_rd = '0;
        req_wr = '0;
    endtask

    task automatic set_req(input int unsigned i, input bit rd, input bit wr,
                           input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        req_rd[i] = rd;
        req_wr[i] = wr;
        req_addr[i*ADDR_W +: ADDR_W]  = a;
        req_wdata[i*DATA_W +: DATA_W] = d;
    endtask

    task automatic new_req(input int unsigned i);
        int unsigned r;
        r = $urandom_range(0, 99);
        set_req(i, (r < 45) || (r >= 90), r >= 45, ADDR_W'($urandom), DATA_W'($urandom));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int unsigned order [6] = '{0, 3, 6, 0, 3, 6};
        rst = 1'b1; req_rd = '0; req_wr = '0; req_addr = '0; req_wdata = '0; mem_rdata = '0;
        cyc = 0; m_rr = 0; m_cnt = 0; m_cnt_s = 0; m_err = 1'b0;
        for (int unsigned k = 0; k < MAXCYC; k++) exp_valid[k] = '0;
        repeat (2) @(posedge clk);
        #1;
        step(1'b1);

        // Single MAC read, returned two cycles later
        set_req(4, 1'b1, 1'b0, 10'h03A, '0);
        step(1'b0);
        check_eq("t1_grant", 64'(obs_grant), 64'(7'b0010000));
        clear_reqs();
        step(1'b0);
        step(1'b0);
        check_eq("t1_rd_valid", 64'(obs_valid), 64'(7'b0010000));

        // Round-robin among writers 0, 3, 6
        step(1'b1);
        for (int unsigned s = 0; s < 7; s += 3) set_req(s, 1'b0, 1'b1, ADDR_W'(s), DATA_W'($urandom));
        for (int k = 0; k < 6; k++) begin
            step(1'b0);
            check_eq("t2_order", 64'(obs_grant), 64'(onehot(order[k])));
        end
        step(1'b0);
        check_eq("t2_conflict_cnt", 64'(obs_cnt), 64'(6));
        clear_reqs();
        step(1'b0); step(1'b0);

        // LAYERNORM read then SOFTMAX write
        step(1'b1);
        set_req(5, 1'b1, 1'b0, 10'h0AA, '0);
        set_req(6, 1'b0, 1'b1, 10'h100, 22'h2A5A5A);
        step(1'b0);
        check_eq("t3_grant_ln", 64'(obs_grant), 64'(onehot(5)));
        req_rd[5] = 1'b0;
        step(1'b0);
        check_eq("t3_grant_sm", 64'(obs_grant), 64'(onehot(6)));
        check_eq("t3_wdata", 64'(obs_wdata), 64'(22'h2A5A5A));
        check_eq("t3_wen", 64'(obs_wen), 64'(1));
        req_wr[6] = 1'b0;
        step(1'b0);
        check_eq("t3_rd_valid", 64'(obs_valid), 64'(onehot(5)));
        step(1'b0);
        check_eq("t3_no_wr_valid", 64'(obs_valid), 64'(0));

        // BUS_FSM read+write collision
        set_req(0, 1'b1, 1'b1, 10'h055, 22'h12345);
        step(1'b0);
        check_eq("t4_wen", 64'(obs_wen), 64'(1));
        clear_reqs();
        step(1'b0);
        check_eq("t4_err", 64'(obs_err), 64'(1));
        step(1'b0);
        check_eq("t4_no_valid", 64'(obs_valid), 64'(0));
        check_eq("t4_err_held", 64'(obs_err), 64'(1));

        // Reset with reads in flight
        set_req(2, 1'b1, 1'b0, 10'h011, '0);
        step(1'b0);
        check_eq("t5_grant_t", 64'(obs_grant), 64'(onehot(2)));
        req_rd[2] = 1'b0;
        set_req(3, 1'b1, 1'b0, 10'h022, '0);
        step(1'b1);
        check_eq("t5_grant_rst", 64'(obs_grant), 64'(0));
        set_req(1, 1'b1, 1'b0, 10'h033, '0);
        step(1'b0);
        check_eq("t5_grant_scan0", 64'(obs_grant), 64'(onehot(1)));
        check_eq("t5_no_valid_t2", 64'(obs_valid), 64'(0));
        check_eq("t5_cnt_zero", 64'(obs_cnt), 64'(0));
        req_rd[1] = 1'b0;
        step(1'b0);
        check_eq("t5_no_valid_t3", 64'(obs_valid), 64'(0));
        clear_reqs();
        step(1'b0); step(1'b0);

        // Saturation of a 4-bit conflict counter
        step(1'b1);
        set_req(1, 1'b0, 1'b1, 10'h001, 22'h1);
        set_req(2, 1'b0, 1'b1, 10'h002, 22'h2);
        repeat (20) step(1'b0);
        clear_reqs();
        step(1'b0);
        check_eq("t6_cnt16", 64'(obs_cnt), 64'(20));
        check_eq("t6_cnt4_sat", 64'(obs_cnt_s), 64'(15));

        // Random traffic with occasional resets
        obs_grant = '0;
        for (int n = 0; n < 2000; n++) begin
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                if (obs_grant[i]) begin
                    if ($urandom_range(0, 1) == 0) begin
                        req_rd[i] = 1'b0;
                        req_wr[i] = 1'b0;
                    end else begin
                        new_req(i);
                    end
                end else if (!(req_rd[i] || req_wr[i]) && ($urandom_range(0, 99) < 30)) begin
                    new_req(i);
                end
            end
            step((n % 500) == 250);
        end
        clear_reqs();
        repeat (RD_LAT + 1) step(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
